// File: rtl/rr_onehot_grant_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master drives requests and release; the slave (arbiter) drives the grant outputs.
interface rr_onehot_grant_if;
  logic [3:0] i_req;
  logic       i_release;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_busy;
  logic       o_timeout;

  modport master (
    output i_req, i_release,
    input  o_grant, o_grant_idx, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_release,
    output o_grant, o_grant_idx, o_busy, o_timeout
  );
endinterface

// File: rtl/rr_onehot_grant.sv
// Four-requester round-robin arbiter with a hold limit. Grant is always zero or one-hot,
// and every grant is followed by a GAP cycle plus an IDLE cycle before the next one.
module rr_onehot_grant #(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_onehot_grant_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  // With the timeout disabled the counter simply parks at its all-ones value.
  localparam logic [HOLD_W-1:0] CNT_LIMIT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [1:0]        r_grant_idx, w_grant_idx_nxt;
  logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              w_found;
  logic [1:0]        w_winner;

  // Rotating priority search starting at the pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && bus.i_req[r_ptr + 2'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 2'(i);
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latches).
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_grant_idx_nxt = r_grant_idx;
    w_cnt_nxt       = r_cnt;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt     = S_GRANT;
          w_grant_idx_nxt = w_winner;
          w_ptr_nxt       = w_winner + 2'd1;
          w_cnt_nxt       = HOLD_W'(1);
        end
      end
      S_GRANT: begin
        if (bus.i_release || !bus.i_req[r_grant_idx]) begin
          w_state_nxt = S_GAP;
        end else if ((MAX_HOLD != 0) && (r_cnt == CNT_LIMIT)) begin
          w_state_nxt   = S_GAP;
          w_timeout_nxt = 1'b1;
        end else if (r_cnt != CNT_LIMIT) begin
          w_cnt_nxt = r_cnt + HOLD_W'(1);
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_grant_idx <= 2'd0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Outputs decode straight from registered state, so async reset clears them at once.
  assign bus.o_busy      = (r_state == S_GRANT);
  assign bus.o_grant     = bus.o_busy ? (4'b0001 << r_grant_idx) : 4'b0000;
  assign bus.o_grant_idx = bus.o_busy ? r_grant_idx : 2'd0;
  assign bus.o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_onehot_grant.sv
// Bench for rr_onehot_grant: directed sequences checked through an expectation queue,
// then a long randomised run checking the grant invariants and round-robin fairness.
module tb_rr_onehot_grant;

  logic clk;
  logic rst_n;

  rr_onehot_grant_if bus ();

  rr_onehot_grant #(.MAX_HOLD(15), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       timeout;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    idx_of = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) idx_of = 2'(i);
  endfunction

  // Pops one expectation per cycle, just after the edge that should produce it.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".grant"},   32'(bus.o_grant),   32'(e.grant));
      check({e.tag, ".busy"},    32'(bus.o_busy),    32'(|e.grant));
      check({e.tag, ".timeout"}, 32'(bus.o_timeout), 32'(e.timeout));
      if (e.grant != 4'b0000)
        check({e.tag, ".idx"}, 32'(bus.o_grant_idx), 32'(idx_of(e.grant)));
    end
  end

  // Called at a falling edge: drive inputs for the next rising edge and queue the result.
  task automatic cyc(input string tag, input logic [3:0] req, input logic rel,
                     input logic [3:0] exp_grant, input logic exp_to);
    exp_t e;
    bus.i_req     = req;
    bus.i_release = rel;
    e.tag = tag; e.grant = exp_grant; e.timeout = exp_to;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.i_req     = 4'b0000;
    bus.i_release = 1'b0;
    @(negedge clk);
    check("rst.grant",   32'(bus.o_grant),     32'h0);
    check("rst.idx",     32'(bus.o_grant_idx), 32'h0);
    check("rst.busy",    32'(bus.o_busy),      32'h0);
    check("rst.timeout", 32'(bus.o_timeout),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         wait_cnt [4];
    logic [3:0] prev_grant;
    logic [3:0] req_r;

    // Full request load with a release one cycle after each grant.
    do_reset();
    cyc("rr0", 4'b1111, 1'b0, 4'b0001, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] nxt;
      nxt = 4'b0001 << (k % 4);
      cyc("rr_rel",  4'b1111, 1'b1, 4'b0000, 1'b0);
      cyc("rr_idle", 4'b1111, 1'b0, 4'b0000, 1'b0);
      cyc("rr_gnt",  4'b1111, 1'b0, nxt,     1'b0);
    end
    cyc("rr_end", 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc("rr_end", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Single requester, then owner withdraws.
    do_reset();
    cyc("single",   4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc("withdraw", 4'b0000, 1'b0, 4'b0000, 1'b0);
    cyc("withdraw", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Hold limit: 15 granted cycles, timeout pulse, then regrant.
    do_reset();
    for (int k = 0; k < 15; k++) cyc("hold", 4'b0010, 1'b0, 4'b0010, 1'b0);
    cyc("hold_to",   4'b0010, 1'b0, 4'b0000, 1'b1);
    cyc("hold_idle", 4'b0010, 1'b0, 4'b0000, 1'b0);
    cyc("regrant",   4'b0010, 1'b0, 4'b0010, 1'b0);
    cyc("regrant_rel", 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc("regrant_rel", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Release on the same edge the hold limit is reached: no timeout.
    do_reset();
    for (int k = 0; k < 15; k++) cyc("relhit", 4'b0010, 1'b0, 4'b0010, 1'b0);
    cyc("relhit_x", 4'b0010, 1'b1, 4'b0000, 1'b0);
    cyc("relhit_y", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant, then pointer restarts at 0.
    do_reset();
    cyc("mid", 4'b0001, 1'b0, 4'b0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async.grant",   32'(bus.o_grant),   32'h0);
    check("async.busy",    32'(bus.o_busy),    32'h0);
    check("async.timeout", 32'(bus.o_timeout), 32'h0);
    bus.i_req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    check("inrst.grant", 32'(bus.o_grant), 32'h0);
    rst_n = 1'b1;
    cyc("post_rst", 4'b1000, 1'b0, 4'b1000, 1'b0);
    cyc("post_rst_rel", 4'b0000, 1'b1, 4'b0000, 1'b0);
    check("sb.drained", 32'(sb.size()), 32'h0);

    // Randomised traffic: invariants every cycle, fairness on each new grant.
    do_reset();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    prev_grant = 4'b0000;
    req_r      = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) req_r[$urandom_range(3)] ^= 1'b1;
      bus.i_req     = req_r;
      bus.i_release = ($urandom_range(5) == 0);
      @(posedge clk);
      #1;
      check("inv.onehot", 32'($onehot0(bus.o_grant)), 32'h1);
      check("inv.busy",   32'(bus.o_busy), 32'(|bus.o_grant));
      if (bus.o_timeout) check("inv.to_idle", 32'(bus.o_grant), 32'h0);
      for (int i = 0; i < 4; i++) if (!bus.i_req[i]) wait_cnt[i] = 0;
      if (prev_grant == 4'b0000 && bus.o_grant != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.o_grant[i]) begin
            wait_cnt[i] = 0;
          end else if (bus.i_req[i]) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > 3) check("fair", 32'(wait_cnt[i]), 32'd3);
          end
        end
      end
      prev_grant = bus.o_grant;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_onehot_grant.md
Name: rr_onehot_grant

Overview:
- Four-requester round-robin arbiter. Produces the one-hot grant vector that the one-hot/validity checker consumes.
- Sits between four request sources and a shared resource.
- Holds a grant until the owner releases it, drops its request, or exceeds a hold limit.
- Guarantees the grant is either all-zero or exactly one-hot on every cycle.

Parameters:
- MAX_HOLD, 15, maximum cycles a grant may be held before forced revocation; 0 disables the timeout.
- HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; bit i set means requester i wants the resource.
- release  input  1  the current owner returns the grant; sampled only in GRANT.
- grant  output  4  one-hot grant vector; all-zero when idle.
- grant_idx  output  2  binary index of the current owner; valid only while busy=1.
- busy  output  1  equals OR of grant.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0000, grant_idx=00, busy=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Outputs clear immediately, without waiting for a clock edge, including when reset arrives mid-grant.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ... modulo 4.
  - Next edge: grant=onehot(winner), grant_idx=winner, busy=1, ptr=winner+1 mod 4, counter=1, go to GRANT.
  - Latency is 1 cycle from req sampled to grant visible.
  - If req=0, remain in IDLE with all outputs zero.
- GRANT: grant held stable. Exit conditions are evaluated each edge in priority order:
  - (a) release=1. Go to GAP, timeout=0.
  - (b) req[grant_idx]=0 (owner withdrew). Go to GAP, timeout=0.
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD. Go to GAP, timeout=1 for exactly one cycle.
  - Otherwise counter increments and saturates at MAX_HOLD.
  - release together with a counter hit is treated as (a); no timeout pulse.
- GAP:
  - grant=0000, busy=0 for exactly one cycle, then go to IDLE.
  - Requests are not evaluated in GAP. Re-arbitration happens in the following IDLE cycle.
  - Minimum turnaround between two grants is therefore 2 zero-grant cycles: GAP then IDLE.
- Pointer update: ptr changes only on grant issue. A revoked owner becomes lowest priority.
- release asserted outside GRANT is ignored.
- req changes on non-owner bits during GRANT have no effect.
- Invariants, every cycle:
  - grant is in {0000, 0001, 0010, 0100, 1000}.
  - busy == |grant.
  - timeout is high only in the cycle after a GRANT-to-GAP exit caused by condition (c).

Test Plan:
- Reset, then req=1111 held, release pulsed 1 cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001, with 2 zero cycles between grants.
- After reset, req=0100 → grant=0100 one cycle later, grant_idx=10. Drop req to 0000 → grant=0000 next cycle, timeout stays 0.
- MAX_HOLD=15, req=0010 held, no release → grant high for 15 cycles, then grant=0000 with timeout=1 for one cycle. Regrant 0010 after IDLE.
- release and counter==MAX_HOLD on the same edge → grant clears, timeout=0.
- rst_n low mid-grant, between clock edges → grant=0000 and busy=0 immediately. After release of reset with req=1000, ptr is 0, so grant=1000 appears after one IDLE cycle.
- Randomised req/release for 10k cycles → a one-hot/zero assertion on grant never fires. Each continuously requesting source is granted within 3 other grants.
